mem_access_stage: RTL and testbench

- Pipeline stage directly upstream of the writeback stage.
- Accepts one executed instruction at a time from the execute stage and performs its load or store over a valid/ready data-memory port.
- Aligns and extends load data, then presents a registered result to writeback: valid, pc, inst, inst_id, rf_wen, reg_addr, wdata.
- Non-memory instructions pass through with 1-cycle latency.

---
 rtl/mem_access_stage.sv | 131 +++++++++++++
 tb/tb_mem_access_stage.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage: performs load/store over a valid/ready memory port and registers results for writeback
module mem_access_stage #(
    parameter int XLEN      = 32,
    parameter int IID_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [XLEN-1:0]      in_pc,
    input  logic [31:0]          in_inst,
    input  logic [IID_WIDTH-1:0] in_inst_id,
    input  logic                 in_is_load,
    input  logic                 in_is_store,
    input  logic [2:0]           in_funct3,
    input  logic [XLEN-1:0]      in_addr,
    input  logic [XLEN-1:0]      in_store_data,
    input  logic [XLEN-1:0]      in_alu_result,
    input  logic                 in_rf_wen,
    input  logic [4:0]           in_reg_addr,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic [XLEN-1:0]      mem_req_addr,
    output logic                 mem_req_wen,
    output logic [31:0]          mem_req_wdata,
    output logic [3:0]           mem_req_wmask,
    input  logic                 mem_resp_valid,
    input  logic [31:0]          mem_resp_rdata,
    output logic                 wb_valid,
    output logic [XLEN-1:0]      wb_pc,
    output logic [31:0]          wb_inst,
    output logic [IID_WIDTH-1:0] wb_inst_id,
    output logic                 wb_rf_wen,
    output logic [4:0]           wb_reg_addr,
    output logic [XLEN-1:0]      wb_wdata,
    output logic                 wb_misaligned
);
    localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2;
    logic [1:0]           state;
    logic [XLEN-1:0]      pc_q, addr_q, store_data_q;
    logic [31:0]          inst_q;
    logic [IID_WIDTH-1:0] iid_q;
    logic                 is_load_q, is_store_q, rf_wen_q;
    logic [2:0]           f3_q;
    logic [4:0]           rd_q;
    logic                 accept, in_mem, misal;
    logic [7:0]           ld_byte;
    logic [15:0]          ld_half;
    logic [XLEN-1:0]      ld_data;
    assign in_ready = state == IDLE;
    assign accept   = in_valid & in_ready;
    assign in_mem   = in_is_load | in_is_store;
    // funct3 encodings 3/6/7 (loads) and >2 (stores) fold into the misaligned path
    assign misal = (in_funct3[1:0] == 2'b01 & in_addr[0]) | (in_funct3[1:0] == 2'b10 & |in_addr[1:0]) |
                   (in_funct3[1:0] == 2'b11) | (in_funct3[2] & (in_is_store | in_funct3[1]));
    assign mem_req_valid = state == REQ;
    assign mem_req_addr  = {addr_q[XLEN-1:2], 2'b00};
    assign mem_req_wen   = is_store_q;
    assign mem_req_wdata = f3_q[1:0] == 2'b00 ? {4{store_data_q[7:0]}} :
                           f3_q[1:0] == 2'b01 ? {2{store_data_q[15:0]}} : store_data_q;
    assign mem_req_wmask = !is_store_q           ? 4'b0000 :
                           f3_q[1:0] == 2'b00    ? 4'b0001 << addr_q[1:0] :
                           f3_q[1:0] == 2'b01    ? 4'b0011 << {addr_q[1], 1'b0} : 4'b1111;
    assign ld_byte = addr_q[1] ? (addr_q[0] ? mem_resp_rdata[31:24] : mem_resp_rdata[23:16])
                               : (addr_q[0] ? mem_resp_rdata[15:8]  : mem_resp_rdata[7:0]);
    assign ld_half = addr_q[1] ? mem_resp_rdata[31:16] : mem_resp_rdata[15:0];
    assign ld_data = f3_q[1:0] == 2'b00 ? {{24{~f3_q[2] & ld_byte[7]}}, ld_byte} :
                     f3_q[1:0] == 2'b01 ? {{16{~f3_q[2] & ld_half[15]}}, ld_half} : mem_resp_rdata;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            pc_q          <= '0;
            addr_q        <= '0;
            store_data_q  <= '0;
            inst_q        <= '0;
            iid_q         <= '0;
            is_load_q     <= 1'b0;
            is_store_q    <= 1'b0;
            rf_wen_q      <= 1'b0;
            f3_q          <= '0;
            rd_q          <= '0;
            wb_valid      <= 1'b0;
            wb_pc         <= '0;
            wb_inst       <= '0;
            wb_inst_id    <= '0;
            wb_rf_wen     <= 1'b0;
            wb_reg_addr   <= '0;
            wb_wdata      <= '0;
            wb_misaligned <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            if (accept) begin
                pc_q         <= in_pc;
                addr_q       <= in_addr;
                store_data_q <= in_store_data;
                inst_q       <= in_inst;
                iid_q        <= in_inst_id;
                is_load_q    <= in_is_load;
                is_store_q   <= in_is_store;
                rf_wen_q     <= in_rf_wen;
                f3_q         <= in_funct3;
                rd_q         <= in_reg_addr;
            end
            // non-memory and faulting accesses retire straight from IDLE
            if (accept && (!in_mem || misal)) begin
                wb_valid      <= 1'b1;
                wb_pc         <= in_pc;
                wb_inst       <= in_inst;
                wb_inst_id    <= in_inst_id;
                wb_reg_addr   <= in_reg_addr;
                wb_rf_wen     <= !in_mem & in_rf_wen;
                wb_wdata      <= in_mem ? '0 : in_alu_result;
                wb_misaligned <= in_mem;
            end else if (accept) begin
                state <= REQ;
            end
            if (state == REQ && mem_req_ready) state <= RESP;
            if (state == RESP && mem_resp_valid) begin
                state         <= IDLE;
                wb_valid      <= 1'b1;
                wb_pc         <= pc_q;
                wb_inst       <= inst_q;
                wb_inst_id    <= iid_q;
                wb_reg_addr   <= rd_q;
                wb_rf_wen     <= is_load_q & rf_wen_q;
                wb_wdata      <= is_load_q ? ld_data : '0;
                wb_misaligned <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed vectors with hand-computed results for mem_access_stage
module tb_mem_access_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] in_pc, in_inst, in_addr, in_store_data, in_alu_result;
    logic [7:0]  in_inst_id;
    logic        in_is_load, in_is_store, in_rf_wen;
    logic [2:0]  in_funct3;
    logic [4:0]  in_reg_addr;
    logic        mem_req_valid, mem_req_ready, mem_req_wen, mem_resp_valid;
    logic [31:0] mem_req_addr, mem_req_wdata, mem_resp_rdata;
    logic [3:0]  mem_req_wmask;
    logic        wb_valid, wb_rf_wen, wb_misaligned;
    logic [31:0] wb_pc, wb_inst, wb_wdata;
    logic [7:0]  wb_inst_id;
    logic [4:0]  wb_reg_addr;
    int n_tests = 0;
    int n_fail  = 0;

    mem_access_stage #(.XLEN(32), .IID_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .in_inst_id(in_inst_id),
        .in_is_load(in_is_load), .in_is_store(in_is_store), .in_funct3(in_funct3),
        .in_addr(in_addr), .in_store_data(in_store_data), .in_alu_result(in_alu_result),
        .in_rf_wen(in_rf_wen), .in_reg_addr(in_reg_addr),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_inst(wb_inst), .wb_inst_id(wb_inst_id),
        .wb_rf_wen(wb_rf_wen), .wb_reg_addr(wb_reg_addr), .wb_wdata(wb_wdata),
        .wb_misaligned(wb_misaligned)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // present one instruction at a negedge; the following posedge accepts it
    task automatic send(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic [31:0] alu, input logic rfw,
                        input logic [4:0] rd, input logic [7:0] iid, input logic [31:0] pc);
        in_valid = 1'b1; in_is_load = ld; in_is_store = st; in_funct3 = f3; in_addr = addr;
        in_store_data = sdata; in_alu_result = alu; in_rf_wen = rfw; in_reg_addr = rd;
        in_inst_id = iid; in_pc = pc; in_inst = pc ^ 32'h0000_0013;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // serve one request: hold ready low for dly cycles checking stability, then respond
    task automatic serve(input string tag, input int dly, input logic [31:0] addr, input logic wen,
                         input logic [3:0] wmask, input logic [31:0] wdata, input logic [31:0] rdata);
        for (int i = 0; i <= dly; i++) begin
            check({tag, " req_valid"}, mem_req_valid, 1'b1);
            check({tag, " req_addr"}, mem_req_addr, addr);
            check({tag, " req_wen"}, mem_req_wen, wen);
            check({tag, " in_ready"}, in_ready, 1'b0);
            if (wen) begin
                check({tag, " wmask"}, mem_req_wmask, wmask);
                check({tag, " wdata"}, mem_req_wdata, wdata);
            end
            mem_req_ready = (i == dly);
            @(negedge clk);
        end
        mem_req_ready = 1'b0;
        check({tag, " req_drop"}, mem_req_valid, 1'b0);
        check({tag, " no_wb_yet"}, wb_valid, 1'b0);
        mem_resp_valid = 1'b1; mem_resp_rdata = rdata;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        check({tag, " wb_valid"}, wb_valid, 1'b1);
        check({tag, " misaligned"}, wb_misaligned, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0; in_funct3 = '0;
        in_addr = '0; in_store_data = '0; in_alu_result = '0; in_rf_wen = 1'b0; in_reg_addr = '0;
        in_inst_id = '0; in_pc = '0; in_inst = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
        repeat (2) @(negedge clk);
        check("rst wb_valid", wb_valid, 1'b0);
        check("rst req_valid", mem_req_valid, 1'b0);
        check("rst wb_wdata", wb_wdata, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst in_ready", in_ready, 1'b1);
        // reset in the middle of a request abandons it
        send(1, 0, 3'd2, 32'h100, 0, 0, 1, 5'd1, 8'h01, 32'h80);
        check("midreq req_valid", mem_req_valid, 1'b1);
        rst_n = 1'b0;
        #1 check("midreq req_drop", mem_req_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        check("midreq wb_valid", wb_valid, 1'b0);
        @(negedge clk);
        check("midreq in_ready", in_ready, 1'b1);
        check("midreq no_wb", wb_valid, 1'b0);
        check("midreq no_req", mem_req_valid, 1'b0);
        // back-to-back ALU ops
        in_valid = 1'b1; in_is_load = 1'b0; in_is_store = 1'b0; in_rf_wen = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_alu_result = 32'h11 * i; in_inst_id = 8'h10 + 8'(i); in_reg_addr = 5'(i);
            @(negedge clk);
            check("alu wb_valid", wb_valid, 1'b1);
            check("alu wdata", wb_wdata, 32'h11 * i);
            check("alu iid", wb_inst_id, 32'h10 + i);
            check("alu rf_wen", wb_rf_wen, 1'b1);
            check("alu misaligned", wb_misaligned, 1'b0);
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("alu pulse end", wb_valid, 1'b0);
        // LB / LBU lane 3
        send(1, 0, 3'd0, 32'h1003, 0, 32'h5555, 1, 5'd7, 8'h21, 32'h200);
        serve("lb", 0, 32'h1000, 1'b0, 4'h0, 0, 32'h80FF_FFFF);
        check("lb wdata", wb_wdata, 32'hFFFF_FF80);
        check("lb rf_wen", wb_rf_wen, 1'b1);
        check("lb rd", wb_reg_addr, 5'd7);
        check("lb pc", wb_pc, 32'h200);
        send(1, 0, 3'd4, 32'h1003, 0, 0, 1, 5'd7, 8'h22, 32'h204);
        serve("lbu", 0, 32'h1000, 1'b0, 4'h0, 0, 32'h80FF_FFFF);
        check("lbu wdata", wb_wdata, 32'h0000_0080);
        // SH with delayed ready
        send(0, 1, 3'd1, 32'h2002, 32'h1234_ABCD, 32'h7777, 1, 5'd3, 8'h30, 32'h208);
        serve("sh", 4, 32'h2000, 1'b1, 4'b1100, 32'hABCD_ABCD, 32'hDEAD_BEEF);
        check("sh rf_wen", wb_rf_wen, 1'b0);
        check("sh wdata", wb_wdata, 32'h0);
        check("sh in_ready", in_ready, 1'b1);
        // SB lane 1
        send(0, 1, 3'd0, 32'h5001, 32'h0000_00EF, 0, 0, 5'd0, 8'h31, 32'h20C);
        serve("sb", 1, 32'h5000, 1'b1, 4'b0010, 32'hEFEF_EFEF, 32'h0);
        // misaligned LW: no request, immediate fault writeback
        send(1, 0, 3'd2, 32'h3001, 0, 32'h9999, 1, 5'd4, 8'h40, 32'h210);
        check("mis wb_valid", wb_valid, 1'b1);
        check("mis flag", wb_misaligned, 1'b1);
        check("mis rf_wen", wb_rf_wen, 1'b0);
        check("mis wdata", wb_wdata, 32'h0);
        check("mis no_req", mem_req_valid, 1'b0);
        check("mis in_ready", in_ready, 1'b1);
        // undefined load funct3 behaves as misaligned
        send(1, 0, 3'd3, 32'h3000, 0, 0, 1, 5'd4, 8'h41, 32'h214);
        check("badf3 flag", wb_misaligned, 1'b1);
        check("badf3 no_req", mem_req_valid, 1'b0);
        // spurious response in IDLE, then LH upper half
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        check("spur wb_valid", wb_valid, 1'b0);
        check("spur in_ready", in_ready, 1'b1);
        send(1, 0, 3'd1, 32'h4002, 0, 0, 1, 5'd9, 8'hA5, 32'h218);
        serve("lh", 0, 32'h4000, 1'b0, 4'h0, 0, 32'h7FFE_0000);
        check("lh wdata", wb_wdata, 32'h0000_7FFE);
        check("lh iid", wb_inst_id, 8'hA5);
        check("lh inst", wb_inst, 32'h218 ^ 32'h13);
        @(negedge clk);
        check("lh pulse end", wb_valid, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
